// File: rtl/score_bcd_converter.sv
// Iterative binary-to-BCD converter (double-dabble, one bit per displayClk) feeding
// the 4-digit seven-segment driver; result is held between updates.
module score_bcd_converter #(
  parameter int BIN_W    = 14,
  parameter int MAX_VAL  = 9999,
  parameter int BLANK_LZ = 0
) (
  input  logic             displayClk,
  input  logic             rst,
  input  logic [BIN_W-1:0] score_in,
  input  logic             score_valid,
  output logic             busy,
  output logic [15:0]      BCD_out,
  output logic             bcd_valid
);
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAXV = BIN_W'(MAX_VAL);

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t             state;
  logic [BIN_W-1:0]   bin_sr;
  logic [BIN_W-1:0]   pend_val;
  logic               pend;
  logic [15:0]        scratch;
  logic [CW-1:0]      cnt;

  logic [BIN_W-1:0]   sat;
  logic [15:0]        adj;
  logic [16+BIN_W-1:0] sh;
  logic [15:0]        blanked;

  assign sat  = (score_in > MAXV) ? MAXV : score_in;
  assign busy = (state != IDLE);

  always_comb begin
    adj = scratch;
    for (int i = 0; i < 4; i++)
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    sh = {adj, bin_sr} << 1;
  end

  // Zero digits above the first nonzero one render blank; the ones digit always shows.
  always_comb begin
    logic lead;
    blanked = scratch;
    lead    = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lead && scratch[4*i +: 4] == 4'd0) blanked[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
  end

  always_ff @(posedge displayClk) begin
    if (rst) begin
      state     <= IDLE;
      bin_sr    <= '0;
      pend_val  <= '0;
      pend      <= 1'b0;
      scratch   <= '0;
      cnt       <= '0;
      BCD_out   <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (score_valid) begin
            bin_sr  <= sat;
            scratch <= '0;
            cnt     <= CW'(BIN_W);
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          {scratch, bin_sr} <= sh;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= DONE;
          if (score_valid) begin
            pend     <= 1'b1;
            pend_val <= sat;
          end
        end
        DONE: begin
          BCD_out   <= (BLANK_LZ != 0) ? blanked : scratch;
          bcd_valid <= 1'b1;
          pend      <= 1'b0;
          scratch   <= '0;
          cnt       <= CW'(BIN_W);
          // A fresh strobe on this edge beats whatever was parked while busy.
          if (score_valid) begin
            bin_sr <= sat;
            state  <= CONVERT;
          end else if (pend) begin
            bin_sr <= pend_val;
            state  <= CONVERT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_score_bcd_converter.sv
// Bench for score_bcd_converter: plain and leading-zero-blanking instances side by side,
// table vectors plus hand sequences, results checked through a scoreboard queue.
module tb_score_bcd_converter;
  logic        displayClk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] score_in = '0;
  logic        score_valid = 1'b0;
  logic        busy0, busy1, bv0, bv1;
  logic [15:0] bcd0, bcd1;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  always #5 displayClk = ~displayClk;

  score_bcd_converter #(.BIN_W(14), .MAX_VAL(9999), .BLANK_LZ(0)) u0 (
    .displayClk(displayClk), .rst(rst), .score_in(score_in), .score_valid(score_valid),
    .busy(busy0), .BCD_out(bcd0), .bcd_valid(bv0));
  score_bcd_converter #(.BIN_W(14), .MAX_VAL(9999), .BLANK_LZ(1)) u1 (
    .displayClk(displayClk), .rst(rst), .score_in(score_in), .score_valid(score_valid),
    .busy(busy1), .BCD_out(bcd1), .bcd_valid(bv1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] plain_ref(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] blank_ref(input int v);
    logic [15:0] p;
    p = plain_ref(v);
    if (p[15:12] == 0) p[15:12] = 4'hF;
    if (p[15:12] == 4'hF && p[11:8] == 0) p[11:8] = 4'hF;
    if (p[11:8] == 4'hF && p[7:4] == 0) p[7:4] = 4'hF;
    return p;
  endfunction

  // Scoreboard: every result pulse must match the oldest outstanding expectation.
  always @(negedge displayClk) begin
    if (bv0) begin
      pulses++;
      if (q0.size() == 0) chk("unexpected_valid0", {16'h0, bcd0}, 32'hDEAD);
      else chk("bcd_plain", {16'h0, bcd0}, {16'h0, q0.pop_front()});
      for (int i = 0; i < 4; i++) chk("nibble_le9", {31'h0, bcd0[4*i +: 4] <= 4'd9}, 32'd1);
    end
    if (bv1) begin
      if (q1.size() == 0) chk("unexpected_valid1", {16'h0, bcd1}, 32'hDEAD);
      else chk("bcd_blank", {16'h0, bcd1}, {16'h0, q1.pop_front()});
    end
  end

  task automatic req(input int v, input logic [15:0] e0, input logic [15:0] e1, input bit push);
    @(negedge displayClk);
    score_in = 14'(v);
    score_valid = 1'b1;
    if (push) begin q0.push_back(e0); q1.push_back(e1); end
    @(posedge displayClk);
    #1 score_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge displayClk);
      #1;
      if (bv0) begin lat = k; break; end
    end
    if (lat == 0) chk("timeout", 32'd0, 32'd1);
  endtask

  typedef struct { int score; logic [15:0] e0; logic [15:0] e1; } vec_t;
  vec_t vecs[13];

  initial begin
    int lat, p0;
    vecs[0]  = '{1234,  16'h1234, 16'h1234};
    vecs[1]  = '{12000, 16'h9999, 16'h9999};
    vecs[2]  = '{9999,  16'h9999, 16'h9999};
    vecs[3]  = '{0,     16'h0000, 16'hFFF0};
    vecs[4]  = '{7,     16'h0007, 16'hFFF7};
    vecs[5]  = '{305,   16'h0305, 16'hF305};
    vecs[6]  = '{1000,  16'h1000, 16'h1000};
    vecs[7]  = '{42,    16'h0042, 16'hFF42};
    vecs[8]  = '{10,    16'h0010, 16'hFF10};
    vecs[9]  = '{100,   16'h0100, 16'hF100};
    vecs[10] = '{16383, 16'h9999, 16'h9999};
    vecs[11] = '{5008,  16'h5008, 16'h5008};
    vecs[12] = '{90,    16'h0090, 16'hFF90};

    repeat (3) @(posedge displayClk);
    #1;
    chk("rst_bcd0", {16'h0, bcd0}, 32'h0);
    chk("rst_bcd1", {16'h0, bcd1}, 32'h0);
    chk("rst_busy", {30'h0, busy0, busy1}, 32'h0);
    chk("rst_valid", {30'h0, bv0, bv1}, 32'h0);
    @(negedge displayClk) rst = 1'b0;

    foreach (vecs[i]) begin
      req(vecs[i].score, vecs[i].e0, vecs[i].e1, 1'b1);
      chk("busy_started", {31'h0, busy0}, 32'd1);
      wait_done(lat);
      chk("latency", lat, 32'd15);
      chk("busy_after", {30'h0, busy0, busy1}, 32'h0);
      @(posedge displayClk);
      #1;
      chk("valid_one_cycle", {31'h0, bv0}, 32'd0);
      chk("held_plain", {16'h0, bcd0}, {16'h0, vecs[i].e0});
    end

    // Back-to-back: 100 is overwritten by 200; 200 starts on the DONE edge.
    p0 = pulses;
    req(42, 16'h0042, 16'hFF42, 1'b1);
    repeat (3) @(posedge displayClk);
    req(100, 16'h0, 16'h0, 1'b0);
    repeat (2) @(posedge displayClk);
    req(200, 16'h0200, 16'hF200, 1'b1);
    wait_done(lat);
    chk("b2b_no_idle", {31'h0, busy0}, 32'd1);
    wait_done(lat);
    chk("b2b_second_lat", lat, 32'd15);
    repeat (20) @(posedge displayClk);
    chk("b2b_pulses", pulses - p0, 32'd2);

    // Reset mid-conversion aborts silently and clears the held result.
    req(321, 16'h0321, 16'hF321, 1'b1);
    wait_done(lat);
    req(8765, 16'h0, 16'h0, 1'b0);
    repeat (4) @(posedge displayClk);
    @(negedge displayClk) rst = 1'b1;
    @(posedge displayClk);
    #1;
    chk("midrst_bcd0", {16'h0, bcd0}, 32'h0);
    chk("midrst_bcd1", {16'h0, bcd1}, 32'h0);
    chk("midrst_busy", {31'h0, busy0}, 32'h0);
    @(negedge displayClk) rst = 1'b0;
    p0 = pulses;
    repeat (20) @(posedge displayClk);
    chk("midrst_no_valid", pulses - p0, 32'd0);
    req(8765, 16'h8765, 16'h8765, 1'b1);
    wait_done(lat);
    chk("after_rst_lat", lat, 32'd15);

    // Strided sweep against a decimal reference (cycle budget rules out every value).
    for (int v = 0; v <= 9999; v += 3) begin
      req(v, plain_ref(v), blank_ref(v), 1'b1);
      wait_done(lat);
    end

    repeat (3) @(posedge displayClk);
    chk("queue0_drained", q0.size(), 32'd0);
    chk("queue1_drained", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
